// File: rtl/mailbox_snapshot_poller.sv
// mailbox_snapshot_poller: burst-reads a 4-word mailbox, commits it atomically to shadow
// registers and write-clears the command byte of word 0 when its flag was set.
module mailbox_snapshot_poller #(
   parameter int CMD_BIT = 31
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic [1:0]  mem_address,
   output logic        mem_chipselect,
   output logic        mem_write,
   output logic [3:0]  mem_byteenable,
   output logic [31:0] mem_writedata,
   output logic        mem_clken,
   input  logic [31:0] mem_readdata,
   output logic [31:0] word0,
   output logic [31:0] word1,
   output logic [31:0] word2,
   output logic [31:0] word3,
   output logic        snap_valid,
   output logic        cmd_valid,
   output logic        busy,
   output logic        overrun
);
   typedef enum logic [2:0] {IDLE, READ, DRAIN, COMMIT, ACK} state_t;
   state_t      state_q, state_d;
   logic [1:0]  issue_q, issue_d, cap_q;
   logic        rd_pend_q, overrun_q, clken_q;
   logic [31:0] stage_q [4];
   logic [31:0] word_q [4];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         issue_q   <= '0;
         cap_q     <= '0;
         rd_pend_q <= 1'b0;
         overrun_q <= 1'b0;
         clken_q   <= 1'b0;
         stage_q   <= '{default: '0};
         word_q    <= '{default: '0};
      end else begin
         state_q   <= state_d;
         issue_q   <= issue_d;
         rd_pend_q <= state_q == READ;
         cap_q     <= issue_q;
         clken_q   <= 1'b1;
         if (start && state_q != IDLE) overrun_q <= 1'b1;
         // read data arrives one cycle after its address, so capture trails issue
         if (rd_pend_q) stage_q[cap_q] <= mem_readdata;
         if (state_q == COMMIT) word_q <= stage_q;
      end
   end

   always_comb begin
      state_d        = state_q;
      issue_d        = issue_q;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = 2'd0;
      mem_byteenable = 4'b0000;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               issue_d = 2'd0;
            end
         end
         READ: begin
            mem_chipselect = 1'b1;
            mem_address    = issue_q;
            issue_d        = issue_q + 2'd1;
            if (issue_q == 2'd3) state_d = DRAIN;
         end
         DRAIN:  state_d = COMMIT;
         COMMIT: state_d = stage_q[0][CMD_BIT] ? ACK : IDLE;
         ACK: begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = 4'b1000;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_writedata = '0;
   assign mem_clken     = clken_q;
   assign snap_valid    = state_q == COMMIT;
   assign cmd_valid     = snap_valid && stage_q[0][CMD_BIT];
   assign busy          = state_q != IDLE;
   assign overrun       = overrun_q;
   assign word0         = word_q[0];
   assign word1         = word_q[1];
   assign word2         = word_q[2];
   assign word3         = word_q[3];
endmodule

// File: doc/mailbox_snapshot_poller.md
# mailbox_snapshot_poller

Avalon-MM master that sits directly upstream of the SoC's 4-word × 32-bit single-port on-chip mailbox RAM. On each start request it burst-reads all four words and commits them atomically to shadow registers for the game-logic fabric. If the command flag in word 0 is set, it writes back to clear that flag, giving software a one-shot command acknowledge. It is the hardware side of the Nios-to-fabric mailbox.

## Interface
- CMD_BIT, 31: bit of word 0 holding the software command flag; must lie in byte 3 (24..31).
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle snapshot request (e.g. per-frame vsync tick)
- mem_address  out  2  mailbox word address
- mem_chipselect  out  1  mailbox access strobe
- mem_write  out  1  1 = write, 0 = read (qualified by chipselect)
- mem_byteenable  out  4  byte lanes for writes
- mem_writedata  out  32  write data
- mem_clken  out  1  mailbox clock enable; constant 1 outside reset
- mem_readdata  in  32  mailbox read data, valid one cycle after address is presented
- word0..word3  out  32 each  committed snapshot of mailbox words 0..3
- snap_valid  out  1  one-cycle pulse: a new snapshot was committed
- cmd_valid  out  1  one-cycle pulse: committed word0 had CMD_BIT set
- busy  out  1  high while a snapshot is in progress
- overrun  out  1  sticky: start arrived while busy; cleared only by reset

## Operation
- States: IDLE, READ, DRAIN, COMMIT, ACK.
- IDLE: start=1 -> READ with issue index 0; otherwise hold.
- READ: drive chipselect=1, write=0, address=issue index; index increments each cycle; after index 3 -> DRAIN.
- Capture pipeline: the read-pending flag and capture index trail issue by one cycle. mem_readdata is loaded into staging[capture index].
- DRAIN: capture word 3, no bus access -> COMMIT.
- COMMIT: copy staging[0..3] to word0..3 simultaneously; pulse snap_valid. If staging[0][CMD_BIT]=1 -> ACK and pulse cmd_valid; else -> IDLE.
- ACK: chipselect=1, write=1, address=0, byteenable=4'b1000, writedata=0. This clears word 0 byte 3 (command flag plus opcode field) -> IDLE.
- word0..3 never change except in COMMIT; consumers never see a torn snapshot.
- start outside IDLE is dropped and sets overrun.
- Idle bus: chipselect=0, write=0, address=0, byteenable=4'b0000, writedata=0.
- Reset values: all outputs 0 except mem_clken. mem_clken=0 while reset_n=0 and 1 from the first cycle after deassertion. State=IDLE, staging=0.
- reset_n asserted mid-operation: outputs drop immediately (asynchronous), so an in-flight ACK write is aborted. No snapshot is committed.

## Timing
- start sampled high in IDLE at cycle T.
- T+1..T+4: reads of addresses 0,1,2,3. Data for address k is captured at the end of cycle T+2+k.
- T+6: COMMIT. word0..3 updated at the end of T+6 (visible from T+7); snap_valid and cmd_valid high during T+6.
- With flag set: ACK write in T+7, IDLE at T+8. Without flag: IDLE at T+7.
- busy high T+1 through the last non-IDLE cycle (T+6 or T+7).
- Minimum start-to-start spacing: 7 cycles (no flag) or 8 cycles (flag set). start in the first IDLE cycle is accepted.
- start in the same cycle COMMIT/ACK completes is dropped, and overrun is set.

## Test plan
- Mailbox preloaded {0x00000011, 0x22, 0x33, 0x44}; start -> reads at addresses 0..3 in T+1..T+4; snap_valid at T+6; word0..3 equal the preload from T+7; no write; cmd_valid=0.
- word0=0x85000123 (CMD_BIT set) -> cmd_valid at T+6; ACK write at T+7 with byteenable 4'b1000 and data 0; the next snapshot reads word0=0x00000123 and cmd_valid=0.
- Mailbox changed by an external write between two snapshots -> outputs hold the old values until the second COMMIT, then all four switch in the same cycle.
- start pulsed at T+3 during READ -> ignored, overrun=1 and stays 1; the snapshot completes normally.
- reset_n low during ACK cycle -> chipselect/write drop immediately; after release, busy=0, outputs 0, and the mailbox retains word0 byte 3 unless the write had already completed.
- Back-to-back start at the first IDLE cycle (T+7 with no flag) -> accepted, no overrun.
